// File: rtl/rename_table_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rename_table_pkg : shared rename constants, also used by rename_decoder  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`ifndef RT_PHYS_REGS
`define RT_PHYS_REGS 32
`endif
`ifndef RT_TAG_W
`define RT_TAG_W(n) $clog2(n)
`endif

package rename_table_pkg;
  localparam int PHYS_REGS     = `RT_PHYS_REGS;
  localparam int ARCH_RENAMED  = 10;
  localparam int FIRST_RENAMED = 2;
  localparam int LAST_RENAMED  = FIRST_RENAMED + ARCH_RENAMED - 1;
  localparam int FIRST_FREE    = FIRST_RENAMED + ARCH_RENAMED;
  localparam int ARCH_W        = 4;

  typedef logic [ARCH_W-1:0] arch_t;

  function automatic logic is_renamed(input arch_t a);
    return (a >= arch_t'(FIRST_RENAMED)) && (a <= arch_t'(LAST_RENAMED));
  endfunction
endpackage

`default_nettype wire

// File: rtl/rename_table_free_list.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | free_list : 2-pop / 2-push circular FIFO of physical tags                |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module free_list #(
  parameter int DEPTH     = 20,
  parameter int TW        = 5,
  parameter int FIRST_TAG = rename_table_pkg::FIRST_FREE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 pop_cnt,
  input  logic [1:0]                 push_valid,
  input  logic [2*TW-1:0]            push_tag,
  output logic [TW-1:0]              head_tag0,
  output logic [TW-1:0]              head_tag1,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [TW-1:0] mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW:0]   space;
  logic [1:0]    n_push;
  logic [1:0]    n_acc;
  logic [TW-1:0] first_tag;

  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] k);
    logic [PW+1:0] s;
    s = {2'b00, p} + (PW+2)'(k);
    if (s >= (PW+2)'(DEPTH)) s = s - (PW+2)'(DEPTH);
    return s[PW-1:0];
  endfunction

  assign head_tag0 = mem[head];
  assign head_tag1 = mem[ptr_add(head, 2'd1)];

  // Pushes that would overflow are dropped so the count saturates at DEPTH.
  always_comb begin
    n_push    = {1'b0, push_valid[0]} + {1'b0, push_valid[1]};
    space     = (CW+1)'(DEPTH) - {1'b0, count} + (CW+1)'(pop_cnt);
    n_acc     = ((CW+1)'(n_push) > space) ? space[1:0] : n_push;
    first_tag = push_valid[0] ? push_tag[TW-1:0] : push_tag[2*TW-1:TW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= TW'(FIRST_TAG + i);
      head  <= '0;
      tail  <= '0;
      count <= CW'(DEPTH);
    end else begin
      if (n_acc != 2'd0) mem[tail] <= first_tag;
      if (n_acc == 2'd2) mem[ptr_add(tail, 2'd1)] <= push_tag[2*TW-1:TW];
      head  <= ptr_add(head, pop_cnt);
      tail  <= ptr_add(tail, n_acc);
      count <= count - CW'(pop_cnt) + CW'(n_acc);
    end
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (rst) count >= CW'(pop_cnt));
  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) (CW+1)'(n_push) <= space);
endmodule

`default_nettype wire

// File: rtl/rename_table.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rename_table : register alias table, done bits and physical free list    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module rename_table #(
  parameter  int PHYS_REGS = rename_table_pkg::PHYS_REGS,
  parameter  int FL_DEPTH  = PHYS_REGS - rename_table_pkg::FIRST_FREE,
  localparam int TW        = `RT_TAG_W(PHYS_REGS)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    ren_valid,
  output logic                                    ren_ready,
  input  logic [1:0]                              dst_valid,
  input  logic [7:0]                              dst_arch,
  output logic [2*TW-1:0]                         dst_new,
  output logic [2*TW-1:0]                         dst_old,
  input  logic [1:0]                              wb_valid,
  input  logic [2*TW-1:0]                         wb_tag,
  input  logic [1:0]                              free_valid,
  input  logic [2*TW-1:0]                         free_tag,
  output logic [rename_table_pkg::ARCH_RENAMED-1:0]    rat_done,
  output logic [rename_table_pkg::ARCH_RENAMED*TW-1:0] rat_aliases
);
  import rename_table_pkg::*;

  localparam int CW = $clog2(FL_DEPTH + 1);

  arch_t           arch0;
  arch_t           arch1;
  logic            need0;
  logic            need1;
  logic [1:0]      need;
  logic            xfer;
  logic [1:0]      pop_cnt;
  logic [1:0]      push_valid;
  logic [1:0]      wb_ok;
  logic [TW-1:0]   head0;
  logic [TW-1:0]   head1;
  logic [TW-1:0]   new0;
  logic [TW-1:0]   new1;
  logic [TW-1:0]   old0;
  logic [TW-1:0]   old1;
  logic [CW-1:0]   fl_count;
  logic [TW-1:0]   alias_q [ARCH_RENAMED];

  always_comb begin
    arch0   = dst_arch[3:0];
    arch1   = dst_arch[7:4];
    need0   = dst_valid[0] && (arch0 >= arch_t'(FIRST_RENAMED));
    need1   = dst_valid[1] && (arch1 >= arch_t'(FIRST_RENAMED));
    need    = {1'b0, need0} + {1'b0, need1};
    ren_ready = (fl_count >= CW'(need));
    xfer    = ren_valid && ren_ready;
    pop_cnt = xfer ? need : 2'd0;

    old0 = is_renamed(arch0) ? alias_q[arch0 - arch_t'(FIRST_RENAMED)] : TW'(arch0);
    new0 = need0 ? head0 : TW'(arch0);
    // Slot1 sees slot0's rename when both target the same architectural reg.
    if (need0 && (arch1 == arch0))
      old1 = new0;
    else if (is_renamed(arch1))
      old1 = alias_q[arch1 - arch_t'(FIRST_RENAMED)];
    else
      old1 = TW'(arch1);
    new1 = need1 ? (need0 ? head1 : head0) : TW'(arch1);

    push_valid[0] = free_valid[0] && (free_tag[TW-1:0] >= TW'(FIRST_RENAMED));
    push_valid[1] = free_valid[1] && (free_tag[2*TW-1:TW] >= TW'(FIRST_RENAMED));
    wb_ok[0]      = wb_valid[0] && (wb_tag[TW-1:0] >= TW'(FIRST_RENAMED));
    wb_ok[1]      = wb_valid[1] && (wb_tag[2*TW-1:TW] >= TW'(FIRST_RENAMED));
  end

  assign dst_new = {new1, new0};
  assign dst_old = {old1, old0};

  free_list #(
    .DEPTH     (FL_DEPTH),
    .TW        (TW),
    .FIRST_TAG (FIRST_FREE)
  ) u_free_list (
    .clk        (clk),
    .rst        (rst),
    .pop_cnt    (pop_cnt),
    .push_valid (push_valid),
    .push_tag   (free_tag),
    .head_tag0  (head0),
    .head_tag1  (head1),
    .count      (fl_count)
  );

  for (genvar r = 0; r < ARCH_RENAMED; r++) begin : g_rat
    localparam arch_t ARCH = arch_t'(r + FIRST_RENAMED);
    logic [TW-1:0] alias_r;
    logic          done_r;
    logic          wb_hit;
    logic          hit0;
    logic          hit1;

    assign wb_hit = (wb_ok[0] && (alias_r == wb_tag[TW-1:0])) ||
                    (wb_ok[1] && (alias_r == wb_tag[2*TW-1:TW]));
    assign hit0   = xfer && need0 && (arch0 == ARCH);
    assign hit1   = xfer && need1 && (arch1 == ARCH);

    // A rename in the same cycle overrides a writeback to the old tag.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        alias_r <= TW'(r + FIRST_RENAMED);
        done_r  <= 1'b1;
      end else if (hit1) begin
        alias_r <= new1;
        done_r  <= 1'b0;
      end else if (hit0) begin
        alias_r <= new0;
        done_r  <= 1'b0;
      end else if (wb_hit) begin
        done_r  <= 1'b1;
      end
    end

    assign alias_q[r]              = alias_r;
    assign rat_aliases[r*TW +: TW] = alias_r;
    assign rat_done[r]             = done_r;
  end

  a_dst0_legal: assert property (@(posedge clk) disable iff (rst)
    (ren_valid && dst_valid[0]) |-> (arch0 <= arch_t'(LAST_RENAMED)));
  a_dst1_legal: assert property (@(posedge clk) disable iff (rst)
    (ren_valid && dst_valid[1]) |-> (arch1 <= arch_t'(LAST_RENAMED)));
endmodule

`default_nettype wire

// File: tb/tb_rename_table.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rename_table : directed bench with an alias-map / tag-queue model     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_rename_table;
  localparam int PR  = 32;
  localparam int FLD = 20;
  localparam int TW  = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            ren_valid;
  logic            ren_ready;
  logic [1:0]      dst_valid;
  logic [7:0]      dst_arch;
  logic [2*TW-1:0] dst_new;
  logic [2*TW-1:0] dst_old;
  logic [1:0]      wb_valid;
  logic [2*TW-1:0] wb_tag;
  logic [1:0]      free_valid;
  logic [2*TW-1:0] free_tag;
  logic [9:0]      rat_done;
  logic [10*TW-1:0] rat_aliases;

  rename_table #(.PHYS_REGS(PR), .FL_DEPTH(FLD)) dut (
    .clk(clk), .rst(rst), .ren_valid(ren_valid), .ren_ready(ren_ready),
    .dst_valid(dst_valid), .dst_arch(dst_arch), .dst_new(dst_new), .dst_old(dst_old),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .free_valid(free_valid), .free_tag(free_tag),
    .rat_done(rat_done), .rat_aliases(rat_aliases)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit active   = 0;

  // Model: architectural map, done bits and an ordered queue of free tags.
  int m_alias [16];
  bit m_done  [16];
  int fl [$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int alias_of(input int r);
    return int'(rat_aliases[(r-2)*TW +: TW]);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 16; r++) begin
      m_alias[r] = r;
      m_done[r]  = 1'b1;
    end
    fl.delete();
    for (int t = 12; t < PR; t++) fl.push_back(t);
  endtask

  // Rename the two slots in program order against a scratch copy of the map.
  task automatic predict(output int need, output bit rdy,
                         output int n0, output int o0, output int n1, output int o1);
    int tmp [16];
    int a0, a1, k;
    tmp  = m_alias;
    a0   = int'(dst_arch[3:0]);
    a1   = int'(dst_arch[7:4]);
    need = ((dst_valid[0] && a0 >= 2) ? 1 : 0) + ((dst_valid[1] && a1 >= 2) ? 1 : 0);
    rdy  = (fl.size() >= need);
    k    = 0;
    o0   = tmp[a0];
    if (dst_valid[0] && a0 >= 2) begin
      n0 = (k < fl.size()) ? fl[k] : -1;
      k++;
      tmp[a0] = n0;
    end else n0 = a0;
    o1 = tmp[a1];
    if (dst_valid[1] && a1 >= 2) begin
      n1 = (k < fl.size()) ? fl[k] : -1;
      k++;
      tmp[a1] = n1;
    end else n1 = a1;
  endtask

  task automatic model_step();
    int need, n0, o0, n1, o1, a0, a1, wt;
    bit rdy;
    predict(need, rdy, n0, o0, n1, o1);
    a0 = int'(dst_arch[3:0]);
    a1 = int'(dst_arch[7:4]);
    for (int p = 0; p < 2; p++) begin
      wt = int'(wb_tag[p*TW +: TW]);
      if (wb_valid[p] && wt >= 2)
        for (int r = 2; r <= 11; r++) if (m_alias[r] == wt) m_done[r] = 1'b1;
    end
    if (ren_valid && rdy) begin
      if (dst_valid[0] && a0 >= 2) begin
        m_alias[a0] = n0; m_done[a0] = 1'b0; void'(fl.pop_front());
      end
      if (dst_valid[1] && a1 >= 2) begin
        m_alias[a1] = n1; m_done[a1] = 1'b0; void'(fl.pop_front());
      end
    end
    for (int p = 0; p < 2; p++)
      if (free_valid[p] && int'(free_tag[p*TW +: TW]) >= 2)
        fl.push_back(int'(free_tag[p*TW +: TW]));
  endtask

  // Compare process: every settled cycle outside reset.
  initial begin
    int need, n0, o0, n1, o1;
    bit rdy;
    forever begin
      @(negedge clk);
      if (active && !rst) begin
        predict(need, rdy, n0, o0, n1, o1);
        chk("ren_ready", ren_ready, rdy);
        chk("fl_count", dut.fl_count, fl.size());
        for (int r = 2; r <= 11; r++) begin
          chk($sformatf("alias%0d", r), alias_of(r), m_alias[r]);
          chk($sformatf("done%0d", r), rat_done[r-2], m_done[r]);
        end
        if (ren_valid && rdy) begin
          if (dst_valid[0]) begin
            chk("dst_new0", dst_new[TW-1:0], n0);
            chk("dst_old0", dst_old[TW-1:0], o0);
          end
          if (dst_valid[1]) begin
            chk("dst_new1", dst_new[2*TW-1:TW], n1);
            chk("dst_old1", dst_old[2*TW-1:TW], o1);
          end
        end
      end
    end
  end

  task automatic drive(input bit rv, input logic [1:0] dv, input int a1, input int a0,
                       input logic [1:0] wv, input int wt1, input int wt0,
                       input logic [1:0] fv, input int ft1, input int ft0);
    @(posedge clk);
    if (!rst) model_step();
    #1;
    ren_valid  = rv;
    dst_valid  = dv;
    dst_arch   = {4'(a1), 4'(a0)};
    wb_valid   = wv;
    wb_tag     = {TW'(wt1), TW'(wt0)};
    free_valid = fv;
    free_tag   = {TW'(ft1), TW'(ft0)};
    #1;
  endtask

  task automatic ren(input logic [1:0] dv, input int a1, input int a0);
    drive(1'b1, dv, a1, a0, 2'b00, 0, 0, 2'b00, 0, 0);
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0);
  endtask

  task automatic reset_dut();
    idle();
    @(posedge clk);
    if (!rst) model_step();
    #1;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ren_valid = 0; dst_valid = 0; dst_arch = 0;
    wb_valid = 0; wb_tag = 0; free_valid = 0; free_tag = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    active = 1'b1;
    #1;

    // Reset state and first single rename
    for (int r = 2; r <= 11; r++) chk("rst_alias", alias_of(r), r);
    chk("rst_done", rat_done, 10'h3FF);
    chk("rst_ready", ren_ready, 1);
    ren(2'b01, 0, 5);
    chk("first_new", dst_new[TW-1:0], 12);
    chk("first_old", dst_old[TW-1:0], 5);
    idle();
    chk("alias5_after", alias_of(5), 12);
    chk("done3_after", rat_done[3], 0);

    // Same architectural register in both slots
    reset_dut();
    ren(2'b11, 3, 3);
    chk("dual_new0", dst_new[TW-1:0], 12);
    chk("dual_new1", dst_new[2*TW-1:TW], 13);
    chk("dual_old1", dst_old[2*TW-1:TW], 12);
    idle();
    chk("dual_alias3", alias_of(3), 13);
    chk("dual_count", dut.fl_count, FLD - 2);

    // Exhaust the free list, then one free
    reset_dut();
    for (int i = 0; i < 10; i++) ren(2'b11, 3 + 2 * (i % 5), 2 + 2 * (i % 5));
    ren(2'b11, 3, 2);
    chk("empty_need2", ren_ready, 0);
    ren(2'b00, 0, 0);
    chk("empty_need0", ren_ready, 1);
    drive(1'b0, 2'b01, 0, 2, 2'b00, 0, 0, 2'b01, 0, 12);
    chk("free_no_bypass", ren_ready, 0);
    drive(1'b0, 2'b11, 3, 2, 2'b00, 0, 0, 2'b00, 0, 0);
    chk("one_free_need2", ren_ready, 0);
    ren(2'b01, 0, 2);
    chk("one_free_need1", ren_ready, 1);
    chk("one_free_tag", dst_new[TW-1:0], 12);
    for (int i = 0; i < 10; i++)
      drive(1'b0, 2'b00, 0, 0, 2'b00, 0, 0, 2'b11, 13 + 2 * i, 12 + 2 * i);
    ren(2'b11, 9, 8);
    chk("wrap_new0", dst_new[TW-1:0], 12);
    chk("wrap_new1", dst_new[2*TW-1:TW], 13);
    ren(2'b11, 11, 10);
    ren(2'b10, 6, 0);
    idle();

    // Rename racing a writeback of the old tag
    reset_dut();
    drive(1'b1, 2'b01, 0, 7, 2'b01, 0, 7, 2'b00, 0, 0);
    chk("race_new", dst_new[TW-1:0], 12);
    idle();
    chk("race_done5", rat_done[5], 0);
    drive(1'b0, 2'b00, 0, 0, 2'b10, 12, 0, 2'b00, 0, 0);
    idle();
    chk("wb_done5", rat_done[5], 1);

    // Arch 0/1 destinations and a free of tag 1
    drive(1'b1, 2'b11, 1, 0, 2'b00, 0, 0, 2'b01, 0, 1);
    chk("a0_new", dst_new[TW-1:0], 0);
    chk("a0_old", dst_old[TW-1:0], 0);
    chk("a1_new", dst_new[2*TW-1:TW], 1);
    chk("a1_old", dst_old[2*TW-1:TW], 1);
    idle();
    chk("a01_count", dut.fl_count, FLD - 1);

    // Asynchronous reset in the middle of a stream
    for (int i = 0; i < 6; i++) ren(2'b01, 0, 2 + i);
    idle();
    #1 rst = 1'b1;
    model_reset();
    #1;
    for (int r = 2; r <= 11; r++) chk("arst_alias", alias_of(r), r);
    chk("arst_done", rat_done, 10'h3FF);
    chk("arst_ready", ren_ready, 1);
    chk("arst_count", dut.fl_count, FLD);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    ren(2'b01, 0, 4);
    chk("post_rst_new", dst_new[TW-1:0], 12);
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/rename_table.md
# rename_table

Register alias table plus physical-register free list for the rename stage. Accepts destination architectural registers from the front end, allocates physical tags from the free list, and records done bits as results write back. Recycles tags released at commit. Drives `rat_aliases`/`rat_done` directly into `rename_decoder`, which translates the source fields of the same microop stream.

## Interface

Parameters:
- `PHYS_REGS` (macro): default 32, total physical registers; tag width `TW = $clog2(PHYS_REGS)`.
- `FL_DEPTH`: default `PHYS_REGS-12`, free-list capacity.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ren_valid`  in  1  rename request present.
- `ren_ready`  out  1  request accepted this cycle if `ren_valid`.
- `dst_valid`  in  2  per-slot destination present.
- `dst_arch`  in  8  slot0 `[3:0]`, slot1 `[7:4]`; arch regs 0..15.
- `dst_new`  out  2*TW  allocated tags (slot0 low).
- `dst_old`  out  2*TW  previous mapping, to ROB for freeing at commit.
- `wb_valid`  in  2  writeback ports.
- `wb_tag`  in  2*TW  completing tags.
- `free_valid`  in  2  commit-release ports.
- `free_tag`  in  2*TW  tags returned to free list.
- `rat_done`  out  10  done bit, arch regs 2..11 (bit 0 = arch 2).
- `rat_aliases`  out  10*TW  current tag, arch regs 2..11, packed as `rename_decoder` expects.

## Operation

- Arch 0/1 are hardwired to tags 0/1 and never renamed. Arch 12..15 are illegal as destinations (assertion).
- A slot needs allocation iff `dst_valid` is set and `dst_arch` ≥ 2. `need` = count of such slots (0..2).
- `ren_ready = (fl_count >= need)`, using the count at the start of the cycle. Frees in the same cycle are not bypassed. With `need = 0`, `ren_ready` is always 1.
- Transfer = `ren_valid & ren_ready`. The free list pops `need` tags in order: slot0 takes the head, slot1 takes the next entry (or the head if slot0 needs none).
- `dst_new`/`dst_old` are combinational from current state. They are valid whenever `ren_valid` is high and meaningful only on transfer. For a non-allocating slot, `dst_new = dst_old = arch reg number` (0/1) or don't-care if invalid.
- Same arch in both slots: slot1 is ordered after slot0. `dst_old[slot1] = dst_new[slot0]`, and the final alias is slot1's tag. Both tags are consumed.
- On transfer, each allocating slot sets alias ← new tag and done ← 0.
- Writeback: for each valid `wb_tag`, set done for every arch reg whose current alias equals it. If rename of arch r and writeback of r's old tag occur in the same cycle, the rename wins (done = 0). Tags 0/1 are ignored.
- Free: each valid `free_tag` ≥ 2 is pushed, slot0 then slot1. Push and pop in the same cycle are allowed. Push beyond `FL_DEPTH` is an assertion error, and the count saturates.
- Free list is circular with head/tail pointers and an explicit count. Both pointers wrap modulo `FL_DEPTH`.

## Timing

- Reset state:
  - alias[r] = r for r = 2..11, and all `rat_done` = 1.
  - Free list holds tags 12..PHYS_REGS-1 in ascending order; head = 0, tail = 0, count = `FL_DEPTH` (full).
  - `ren_ready` = 1.
- Reset asserted mid-operation discards all in-flight state immediately.
- Rename update is visible on `rat_aliases`/`rat_done` one cycle after transfer.
- Writeback is visible one cycle later.
- Freed tags are allocatable from the next cycle.
- No internal pipeline; one rename per cycle sustained while the free list has ≥ `need` entries.

## Structure

- Shared header: `PHYS_REGS`, `ARCH_RENAMED` (10), `FIRST_RENAMED` (2), tag-width macro. These are also consumed by `rename_decoder`.
- Sub-module `free_list`: 2-pop/2-push circular FIFO of TW-bit tags, with count and reset-to-sequential-fill.
- Alias/done storage and writeback compare logic live in the top level.

## Test plan

- Reset, then read outputs: aliases = 2..11, `rat_done` = 0x3FF, `ren_ready` = 1. First rename of arch 5 returns `dst_new` = 12, `dst_old` = 5; next cycle alias[5] = 12, done bit 3 = 0.
- Dual rename of arch 3 and arch 3: `dst_new` = {13, 12}, slot1 `dst_old` = 12, final alias = 13, count drops by 2.
- Exhaust the free list with 10 two-dest renames (20 tags): `ren_ready` = 0 for `need` = 2, 1 for `need` = 0. One free of tag 12 then gives `ren_ready` = 1 only for `need` ≤ 1, on the cycle after the free.
- Rename arch 7 while `wb_tag` = old alias of 7 in the same cycle: done[5] stays 0. Writeback of the new tag the next cycle sets done[5] = 1.
- Destination arch 0/1: no pop, count unchanged, `dst_new` = `dst_old` = 0/1, and free of tag 1 is ignored.
- Assert `rst` mid-stream after 6 renames: all outputs return to reset values asynchronously, and count = `FL_DEPTH`.
